// File: rtl/board_editor_pkg.sv
// Shared board geometry, word split and editor FSM encoding.
// The stepper and the display reader use the same address split.
package board_editor_pkg;

    localparam int LOG_BOARD_SIZE = 6;
    localparam int DEF_WORD_W     = 16;
    localparam int LOG_WORD_W     = $clog2(DEF_WORD_W);
    localparam int BOARD_ADDR_W   = 2 * LOG_BOARD_SIZE - LOG_WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } editor_state_t;

endpackage

// File: rtl/board_editor_if.sv
// Borrowed board memory port: request/grant handshake plus BRAM read/write strobes.
interface board_editor_if
    import board_editor_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = BOARD_ADDR_W
);
    logic              bus_req_out;
    logic              bus_gnt_in;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_rd_en_out;
    logic [WORD_W-1:0] mem_rd_data_in;
    logic              mem_wr_en_out;
    logic [WORD_W-1:0] mem_wr_data_out;

    modport master (
        output bus_req_out, mem_addr_out, mem_rd_en_out, mem_wr_en_out, mem_wr_data_out,
        input  bus_gnt_in, mem_rd_data_in
    );

    modport slave (
        input  bus_req_out, mem_addr_out, mem_rd_en_out, mem_wr_en_out, mem_wr_data_out,
        output bus_gnt_in, mem_rd_data_in
    );
endinterface

// File: rtl/board_editor_click_edge.sv
// Registered click edge detector; with BOARD_EDITOR_PAINT_EN it also tracks the
// last edited cell so a held click dragged across the board starts paint edits.
module click_edge
    import board_editor_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      click,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y,
    input  logic                      idle,
    output logic                      start,
    output logic                      paint,
    output logic [LOG_BOARD_SIZE-1:0] cell_x,
    output logic [LOG_BOARD_SIZE-1:0] cell_y
);
    logic click_r;
    logic edge_s;

    // Previous click sample; reset reloads it so a held click cannot retrigger.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            click_r <= click;
        end else begin
            click_r <= click;
        end
    end

    assign edge_s = click & ~click_r;

`ifdef BOARD_EDITOR_PAINT_EN
    logic [LOG_BOARD_SIZE-1:0] cur_x_r;
    logic [LOG_BOARD_SIZE-1:0] cur_y_r;
    logic [LOG_BOARD_SIZE-1:0] last_x_r;
    logic [LOG_BOARD_SIZE-1:0] last_y_r;
    logic                      moved_s;

    // Registered cursor and the cell most recently handed to the editor.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cur_x_r  <= cursor_x;
            cur_y_r  <= cursor_y;
            last_x_r <= cursor_x;
            last_y_r <= cursor_y;
        end else begin
            cur_x_r <= cursor_x;
            cur_y_r <= cursor_y;
            if (start) begin
                last_x_r <= cell_x;
                last_y_r <= cell_y;
            end else begin
                last_x_r <= last_x_r;
                last_y_r <= last_y_r;
            end
        end
    end

    assign moved_s = (cur_x_r != last_x_r) || (cur_y_r != last_y_r);

    // A fresh press toggles at the live cursor; a drag sets at the registered cursor.
    always_comb begin
        start  = 1'b0;
        paint  = 1'b0;
        cell_x = cursor_x;
        cell_y = cursor_y;
        if (idle && edge_s) begin
            start = 1'b1;
        end else if (idle && click && click_r && moved_s) begin
            start  = 1'b1;
            paint  = 1'b1;
            cell_x = cur_x_r;
            cell_y = cur_y_r;
        end else begin
            start = 1'b0;
        end
    end
`else
    assign start  = idle & edge_s;
    assign paint  = 1'b0;
    assign cell_x = cursor_x;
    assign cell_y = cursor_y;
`endif

endmodule

// File: rtl/board_editor.sv
// Turns a click at the cursor into one read-modify-write of a board memory word
// over a borrowed BRAM port. Optional drag painting: BOARD_EDITOR_PAINT_EN.
module board_editor
    import board_editor_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int RD_LAT = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      click_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    board_editor_if.master            bus,
    output logic                      busy_out,
    output logic                      edit_done_out
);
    localparam int LOG_W  = $clog2(WORD_W);
    localparam int ADDR_W = 2 * LOG_BOARD_SIZE - LOG_W;
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    editor_state_t             state_r, state_next_s;
    logic [CNT_W-1:0]          cnt_r, cnt_next_s;
    logic [ADDR_W-1:0]         addr_lat_r, addr_next_s;
    logic [LOG_W-1:0]          bit_r;
    logic                      paint_r;
    logic                      start_s, paint_s, in_bus_s;
    logic [LOG_BOARD_SIZE-1:0] cell_x_s, cell_y_s;
    logic [WORD_W-1:0]         mask_s, wr_word_s;
    logic                      bus_req_r, rd_en_r, wr_en_r, busy_r, done_r;
    logic [ADDR_W-1:0]         addr_r;
    logic [WORD_W-1:0]         wr_data_r;

    click_edge u_click_edge (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .click    (click_in),
        .cursor_x (cursor_x_in),
        .cursor_y (cursor_y_in),
        .idle     (state_r == ST_IDLE),
        .start    (start_s),
        .paint    (paint_s),
        .cell_x   (cell_x_s),
        .cell_y   (cell_y_s)
    );

    // Next state and read-latency countdown; grant loss before the write restarts the request.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_next_s = ST_REQ;
                else         state_next_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.bus_gnt_in) state_next_s = ST_READ;
                else                state_next_s = ST_REQ;
            end
            ST_READ: begin
                cnt_next_s = CNT_W'(RD_LAT - 1);
                if (!bus.bus_gnt_in)  state_next_s = ST_REQ;
                else if (RD_LAT == 1) state_next_s = ST_WRITE;
                else                  state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.bus_gnt_in) begin
                    state_next_s = ST_REQ;
                end else if (cnt_r <= CNT_W'(1)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_WRITE: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    assign in_bus_s    = (state_next_s == ST_REQ)  || (state_next_s == ST_READ) ||
                         (state_next_s == ST_WAIT) || (state_next_s == ST_WRITE);
    assign addr_next_s = start_s ? {cell_y_s, cell_x_s[LOG_BOARD_SIZE-1:LOG_W]} : addr_lat_r;
    assign mask_s      = {{(WORD_W-1){1'b0}}, 1'b1} << bit_r;
    assign wr_word_s   = paint_r ? (bus.mem_rd_data_in | mask_s) : (bus.mem_rd_data_in ^ mask_s);

    // State, latched cell and every output registered from the next state.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            addr_lat_r <= '0;
            bit_r      <= '0;
            paint_r    <= 1'b0;
            bus_req_r  <= 1'b0;
            addr_r     <= '0;
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_data_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            addr_lat_r <= addr_next_s;
            if (start_s) begin
                bit_r   <= cell_x_s[LOG_W-1:0];
                paint_r <= paint_s;
            end else begin
                bit_r   <= bit_r;
                paint_r <= paint_r;
            end
            bus_req_r <= in_bus_s;
            addr_r    <= in_bus_s ? addr_next_s : '0;
            rd_en_r   <= (state_next_s == ST_READ);
            wr_en_r   <= (state_next_s == ST_WRITE);
            if (state_next_s == ST_WRITE) wr_data_r <= wr_word_s;
            else                          wr_data_r <= wr_data_r;
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= (state_next_s == ST_DONE);
        end
    end

    assign bus.bus_req_out     = bus_req_r;
    assign bus.mem_addr_out    = addr_r;
    assign bus.mem_rd_en_out   = rd_en_r;
    assign bus.mem_wr_en_out   = wr_en_r;
    assign bus.mem_wr_data_out = wr_data_r;
    assign busy_out            = busy_r;
    assign edit_done_out       = done_r;

endmodule

// File: tb/tb_board_editor.sv
// Directed bench for board_editor: toggle edits, grant wait/loss, busy clicks, reset,
// and drag painting when BOARD_EDITOR_PAINT_EN is defined.
module tb_board_editor;
    import board_editor_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       click;
    logic [5:0] cursor_x, cursor_y;
    logic       busy, done;

    int checks = 0, errors = 0;
    int cyc, rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, done_cnt, req_cnt, busy_cnt;
    logic [15:0] wr_data_seen;
    logic [7:0]  wr_addr_seen, rd_addr_seen;

    board_editor_if #(.WORD_W(16), .ADDR_W(8)) bus_if ();

    board_editor #(.WORD_W(16), .RD_LAT(2)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .click_in      (click),
        .cursor_x_in   (cursor_x),
        .cursor_y_in   (cursor_y),
        .bus           (bus_if.master),
        .busy_out      (busy),
        .edit_done_out (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; rd_cyc = 0; wr_cyc = 0; done_cyc = 0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; req_cnt = 0; busy_cnt = 0;
        wr_data_seen = 16'h0; wr_addr_seen = 8'h0; rd_addr_seen = 8'h0;
    endtask

    // One clock; outputs sampled 1 time unit after the edge and tallied.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.mem_rd_en_out) begin rd_cnt++; rd_cyc = cyc; rd_addr_seen = bus_if.mem_addr_out; end
        if (bus_if.mem_wr_en_out) begin
            wr_cnt++; wr_cyc = cyc;
            wr_data_seen = bus_if.mem_wr_data_out; wr_addr_seen = bus_if.mem_addr_out;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (bus_if.bus_req_out) req_cnt++;
        if (busy) busy_cnt++;
    endtask

    // Runs until edit_done is seen (bounded), then one more cycle back to IDLE.
    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check_val({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
        step();
        check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic release_click();
        click = 1'b0;
        step();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {27'd0, bus_if.bus_req_out, bus_if.mem_rd_en_out,
                                  bus_if.mem_wr_en_out, busy, done}, 32'd0);
        check_val({tag, "_addr"}, 32'(bus_if.mem_addr_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; click = 1'b0; cursor_x = 6'd0; cursor_y = 6'd0;
        bus_if.bus_gnt_in = 1'b1; bus_if.mem_rd_data_in = 16'h0000;
        clear_mon();
        step(); step();
        check_all_zero("reset");
        check_val("reset_wdata", 32'(bus_if.mem_wr_data_out), 32'd0);
        rst_n = 1'b1;
        step();

        // Toggle at (37,5): word 22, bit 5
        cursor_x = 6'd37; cursor_y = 6'd5;
        clear_mon();
        click = 1'b1;
        run_to_done("e1", 20);
        check_val("e1_rd_cyc", rd_cyc, 32'd2);
        check_val("e1_rd_addr", 32'(rd_addr_seen), 32'd22);
        check_val("e1_wr_cyc", wr_cyc, 32'd4);
        check_val("e1_wr_addr", 32'(wr_addr_seen), 32'd22);
        check_val("e1_wr_data", 32'(wr_data_seen), 32'h0020);
        check_val("e1_done_cyc", done_cyc, 32'd5);
        check_val("e1_wr_cnt", wr_cnt, 32'd1);
        check_val("e1_req_cnt", req_cnt, 32'd4);
        check_val("e1_busy_cnt", busy_cnt, 32'd5);
        release_click();

        // Same cell, bit already set: toggles back
        bus_if.mem_rd_data_in = 16'h0020;
        clear_mon();
        click = 1'b1;
        run_to_done("e2", 20);
        check_val("e2_wr_data", 32'(wr_data_seen), 32'h0000);
        check_val("e2_wr_addr", 32'(wr_addr_seen), 32'd22);
        release_click();

        // Grant withheld for 10 cycles after the edge
        bus_if.mem_rd_data_in = 16'h0000;
        bus_if.bus_gnt_in = 1'b0;
        clear_mon();
        click = 1'b1;
        repeat (10) step();
        check_val("gw_req_cnt", req_cnt, 32'd10);
        check_val("gw_rd_cnt", rd_cnt, 32'd0);
        bus_if.bus_gnt_in = 1'b1;
        run_to_done("gw", 20);
        check_val("gw_rd_cyc", rd_cyc, 32'd11);
        check_val("gw_done_cyc", done_cyc, 32'd14);
        check_val("gw_wr_data", 32'(wr_data_seen), 32'h0020);
        release_click();

        // Grant lost during WAIT at (3,63): word 252, bit 3
        cursor_x = 6'd3; cursor_y = 6'd63;
        bus_if.mem_rd_data_in = 16'hFFFF;
        clear_mon();
        click = 1'b1;
        step(); step(); step();
        bus_if.bus_gnt_in = 1'b0;
        step();
        check_val("gl_req_again", 32'(bus_if.bus_req_out), 32'd1);
        check_val("gl_no_wr", wr_cnt, 32'd0);
        step();
        bus_if.bus_gnt_in = 1'b1;
        run_to_done("gl", 20);
        check_val("gl_rd_cnt", rd_cnt, 32'd2);
        check_val("gl_wr_cnt", wr_cnt, 32'd1);
        check_val("gl_wr_addr", 32'(wr_addr_seen), 32'd252);
        check_val("gl_rd_addr", 32'(rd_addr_seen), 32'd252);
        check_val("gl_wr_data", 32'(wr_data_seen), 32'hFFF7);
        check_val("gl_done_cyc", done_cyc, 32'd9);
        release_click();

        // Second click edge while in WAIT is ignored
        cursor_x = 6'd37; cursor_y = 6'd5;
        bus_if.mem_rd_data_in = 16'h0000;
        clear_mon();
        click = 1'b1;
        step(); step();
        click = 1'b0;
        step();
        click = 1'b1;
        step();
        run_to_done("bc", 20);
        repeat (6) step();
        check_val("bc_done_cnt", done_cnt, 32'd1);
        check_val("bc_wr_cnt", wr_cnt, 32'd1);
        check_val("bc_busy_cnt", busy_cnt, 32'd5);
        release_click();

        // Reset during WAIT with the click held afterwards
        clear_mon();
        click = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check_all_zero("mr");
        rst_n = 1'b1;
        clear_mon();
        repeat (8) step();
        check_val("mr_wr_cnt", wr_cnt, 32'd0);
        check_val("mr_rd_cnt", rd_cnt, 32'd0);
        check_val("mr_busy_cnt", busy_cnt, 32'd0);
        release_click();

`ifdef BOARD_EDITOR_PAINT_EN
        // Drag along row 0: first edit toggles, later ones set
        cursor_x = 6'd0; cursor_y = 6'd0;
        bus_if.mem_rd_data_in = 16'h0000;
        step();
        clear_mon();
        click = 1'b1;
        run_to_done("p0", 20);
        check_val("p0_wr_data", 32'(wr_data_seen), 32'h0001);
        check_val("p0_wr_addr", 32'(wr_addr_seen), 32'd0);
        for (int i = 1; i < 3; i++) begin
            cursor_x = 6'(i);
            clear_mon();
            run_to_done("pn", 20);
            check_val("pn_wr_data", 32'(wr_data_seen), 32'h0001 << i);
            check_val("pn_wr_addr", 32'(wr_addr_seen), 32'd0);
            check_val("pn_wr_cnt", wr_cnt, 32'd1);
        end
        release_click();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_editor.md
# board_editor

Consumer end of the cursor/click interface: turns a user click at the cursor position into a read-modify-write on the board memory. Sits between the user-input front end, which supplies `click`, `cursor_x` and `cursor_y`, and the board BRAM port that the simulation stepper shares. It borrows that port through a request/grant handshake and hands it back after exactly one word update.

## Interface
Parameters:
- `WORD_W`, 16: cells per memory word; must be a power of two, at most BOARD_SIZE.
- `RD_LAT`, 2: BRAM read latency in cycles; must be at least 1.

Ports:
- `clk_in`, in, 1: the single clock.
- `rst_n_in`, in, 1: reset, synchronous and active-low.
- `click_in`, in, 1: debounced click level.
- `cursor_x_in`, in, LOG_BOARD_SIZE: cursor column.
- `cursor_y_in`, in, LOG_BOARD_SIZE: cursor row.
- `bus_req_out`, out, 1: requests the board memory port.
- `bus_gnt_in`, in, 1: the stepper grants the port.
- `mem_addr_out`, out, ADDR_W: word address, where ADDR_W = 2·LOG_BOARD_SIZE − log2(WORD_W).
- `mem_rd_en_out`, out, 1: one-cycle read strobe.
- `mem_rd_data_in`, in, WORD_W: read data, valid RD_LAT cycles after the strobe.
- `mem_wr_en_out`, out, 1: one-cycle write strobe.
- `mem_wr_data_out`, out, WORD_W: write data.
- `busy_out`, out, 1: an edit is in progress.
- `edit_done_out`, out, 1: one-cycle pulse when the write has been issued.

## Operation
- **Click detection:** `click_in` is registered once. A rising edge (current sample 1, previous sample 0) in IDLE latches `cursor_x_in` and `cursor_y_in` from the same cycle.
- **Addressing:**
  - Word address = {y, x[LOG_BOARD_SIZE-1:log2(WORD_W)]}.
  - Bit index = x[log2(WORD_W)-1:0].
  - Bit 0 of a word is the lowest x.
- **Write data:** the captured read word with the indexed bit inverted; all other bits unchanged.
- **FSM states:** IDLE, REQ, READ, WAIT, WRITE, DONE.
  - IDLE → REQ on a detected edge.
  - REQ holds `bus_req_out`=1 and moves to READ in the cycle after `bus_gnt_in`=1 is sampled.
  - READ pulses `mem_rd_en_out` and loads the latency counter.
  - WAIT counts RD_LAT−1 cycles, then moves to WRITE and samples `mem_rd_data_in` in that cycle.
  - WRITE pulses `mem_wr_en_out` with the modified word.
  - DONE pulses `edit_done_out`, drops `bus_req_out` and returns to IDLE.
- **Busy clicks:** click edges in any state other than IDLE are ignored; no queueing.
- **Grant loss:** if `bus_gnt_in` falls in READ or WAIT, the read is abandoned, nothing is written, and the FSM returns to REQ with the same latched coordinates. The stepper must not drop the grant in WRITE; doing so is a protocol violation and the write is still issued.
- **Reset:** reset mid-edit returns to IDLE immediately. No write is issued afterwards and the edge-detect register reloads from `click_in`, so a held click does not retrigger.
- **Drive rules:**
  - `bus_req_out`=1 in states REQ through WRITE.
  - `busy_out`=1 whenever the state is not IDLE.
  - `mem_addr_out` holds the latched word address from REQ through WRITE and is 0 otherwise.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- With the grant already high, an edge at cycle 0 gives:
  - REQ at cycle 1;
  - READ strobe at cycle 2;
  - WRITE at cycle 2+RD_LAT;
  - `edit_done_out` at cycle 3+RD_LAT;
  - IDLE, ready for the next edge, at cycle 4+RD_LAT.
- Each extra cycle of grant wait adds one cycle to the total.
- All outputs come straight from registers; there are no combinational input-to-output paths.

## Configuration
- `BOARD_EDITOR_PAINT_EN` defined:
  - While the click is held and the FSM is in IDLE, a change in the registered cursor (x or y differs from the last edited cell) starts an edit.
  - Paint edits **set** the bit instead of toggling it.
  - The initial rising-edge edit still toggles.
- `BOARD_EDITOR_PAINT_EN` undefined: only rising edges start edits, and every edit toggles.

## Structure
- `common.svh` gets these shared items:
  - an `editor_state_t` enum;
  - `LOG_WORD_W`;
  - `BOARD_ADDR_W`.
- These stay in `common.svh` because the stepper and the display reader use the same address split.
- Sub-module `click_edge` holds the registered rising-edge detector, together with last-cell tracking under the macro.

## Test plan
- Grant tied high, RD_LAT=2, cursor (37,5), BOARD_SIZE=64, WORD_W=16, read data 16'h0000:
  - expect read and write address 5·4+2=22;
  - write data 16'h0020;
  - `edit_done_out` at cycle 5.
- Same cell with read data 16'h0020 → write data 16'h0000 (toggle back).
- Grant held low for 10 cycles after the edge → `bus_req_out` held high for those 10 cycles; the read strobe comes exactly one cycle after the grant rises.
- Grant drops during WAIT → no write strobe; the FSM re-requests the port and then completes with the same address.
- Second click edge during WAIT, and a reset pulse during WAIT:
  - the second edge is ignored, giving exactly one `edit_done_out`;
  - after the reset, all outputs are 0 and no write occurs.
- With `BOARD_EDITOR_PAINT_EN`: hold the click and step the cursor through x=0,1,2 on row 0 with read data 0 → writes 16'h0001, 16'h0002, 16'h0004, all to address 0.
